// File: rtl/tetris_pkg.sv
// Shared board geometry defaults, the cell type and the row-fetch FSM encoding.
package tetris_pkg;

  localparam int BOARD_ROWS_DEF  = 20;
  localparam int BOARD_COLS_DEF  = 10;
  localparam int SQUARE_SIZE_DEF = 21;
  localparam int FRAME_LAST_DEF  = 524;

  // {R,G,B} live in bits [11:0]; the top nibble is carried through untouched.
  typedef logic [15:0] cell_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    SWAP
  } state_t;

endpackage

// File: rtl/row_trigger.sv
// Detects the hs rising edge on the line just before a board row starts (or at
// frame end) and reports which board row has to be fetched next.
module row_trigger #(
  parameter int SQUARE_SIZE = 21,
  parameter int BOARD_ROWS  = 20,
  parameter int FRAME_LAST  = 524
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_hs,
  input  logic [9:0] i_draw_y,
  output logic       o_trigger,
  output logic [7:0] o_target_row
);

  localparam logic [10:0] SQ    = 11'(SQUARE_SIZE);
  localparam logic [10:0] LIMIT = 11'(BOARD_ROWS * SQUARE_SIZE);
  localparam logic [10:0] LAST  = 11'(FRAME_LAST);

  logic        r_hs_prev;
  logic [10:0] w_next_line;
  logic        w_hs_rise;
  logic        w_row_line;
  logic        w_frame_end;

  // One extra bit so DrawY = 1023 cannot wrap to line 0.
  assign w_next_line  = {1'b0, i_draw_y} + 11'd1;
  assign w_hs_rise    = i_hs & ~r_hs_prev;
  assign w_row_line   = ((w_next_line % SQ) == 11'd0) && (w_next_line < LIMIT);
  assign w_frame_end  = ({1'b0, i_draw_y} == LAST);
  assign o_trigger    = w_hs_rise & (w_row_line | w_frame_end);
  assign o_target_row = w_frame_end ? 8'd0 : 8'(w_next_line / SQ);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hs_prev <= 1'b0;
    end else begin
      r_hs_prev <= i_hs;
    end
  end

endmodule

// File: rtl/board_row_scheduler.sv
// Shares the board RAM between the VGA row prefetcher and game logic; the
// displayed row is double-buffered so it only ever changes as a whole row.
module board_row_scheduler
  import tetris_pkg::*;
#(
  parameter int SQUARE_SIZE = SQUARE_SIZE_DEF,
  parameter int BOARD_ROWS  = BOARD_ROWS_DEF,
  parameter int BOARD_COLS  = BOARD_COLS_DEF,
  parameter int FRAME_LAST  = FRAME_LAST_DEF
) (
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         hs,
  input  logic [9:0]                   DrawY,
  input  logic                         game_req,
  input  logic                         game_we,
  input  logic [4:0]                   game_row,
  input  logic [3:0]                   game_col,
  input  logic [15:0]                  game_wdata,
  output logic                         game_gnt,
  output logic                         game_rvalid,
  output logic [15:0]                  game_rdata,
  output logic [7:0]                   mem_addr,
  output logic                         mem_we,
  output logic [15:0]                  mem_wdata,
  input  logic [15:0]                  mem_rdata,
  output logic [BOARD_COLS-1:0][15:0]  Row,
  output logic [7:0]                   rowNum,
  output logic                         row_valid,
  output logic                         fetch_overrun
);

  localparam logic [7:0] COLS8    = 8'(BOARD_COLS);
  localparam logic [3:0] LAST_COL = 4'(BOARD_COLS - 1);

  state_t                  r_state;
  logic [3:0]              r_col;
  logic [3:0]              r_cap_col;
  logic                    r_cap_valid;
  logic [7:0]              r_target;
  logic [7:0]              r_row_num;
  cell_t [BOARD_COLS-1:0]  r_shadow;
  cell_t [BOARD_COLS-1:0]  r_row;
  logic                    r_row_valid;
  logic                    r_overrun;
  logic                    r_rvalid;
  logic                    r_rd_oob;

  logic       w_trigger;
  logic [7:0] w_trig_row;
  logic       w_gnt;
  logic       w_in_range;
  logic [7:0] w_fetch_addr;
  logic [7:0] w_game_addr;

  row_trigger #(
    .SQUARE_SIZE (SQUARE_SIZE),
    .BOARD_ROWS  (BOARD_ROWS),
    .FRAME_LAST  (FRAME_LAST)
  ) u_row_trigger (
    .i_clk        (Clk),
    .i_reset      (reset),
    .i_hs         (hs),
    .i_draw_y     (DrawY),
    .o_trigger    (w_trigger),
    .o_target_row (w_trig_row)
  );

  // The display fetch always wins a same-cycle collision with game logic.
  assign w_gnt        = game_req && (r_state == IDLE) && !w_trigger && !reset;
  assign w_in_range   = (32'(game_row) < BOARD_ROWS) && (32'(game_col) < BOARD_COLS);
  assign w_fetch_addr = 8'(r_target * COLS8 + {4'd0, r_col});
  assign w_game_addr  = 8'({3'd0, game_row} * COLS8 + {4'd0, game_col});

  always_comb begin
    mem_addr  = 8'd0;
    mem_we    = 1'b0;
    mem_wdata = 16'd0;
    if (r_state == FETCH) begin
      mem_addr = w_fetch_addr;
    end else if (w_gnt && w_in_range) begin
      mem_addr = w_game_addr;
      if (game_we) begin
        mem_we    = 1'b1;
        mem_wdata = game_wdata;
      end
    end
  end

  assign game_gnt      = w_gnt;
  assign game_rvalid   = r_rvalid;
  assign game_rdata    = (r_rvalid && !r_rd_oob) ? mem_rdata : 16'd0;
  assign Row           = r_row;
  assign rowNum        = r_row_num;
  assign row_valid     = r_row_valid;
  assign fetch_overrun = r_overrun;

  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_col       <= 4'd0;
      r_cap_col   <= 4'd0;
      r_cap_valid <= 1'b0;
      r_target    <= 8'd0;
      r_row_num   <= 8'd0;
      r_shadow    <= '0;
      r_row       <= '0;
      r_row_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rd_oob    <= 1'b0;
    end else begin
      r_row_valid <= 1'b0;
      r_cap_valid <= 1'b0;
      r_rvalid    <= w_gnt && !game_we;
      r_rd_oob    <= !w_in_range;

      // RAM data for the address issued last cycle lands in the shadow row.
      if (r_cap_valid) begin
        r_shadow[r_cap_col] <= mem_rdata;
      end

      if (w_trigger && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_state  <= FETCH;
            r_col    <= 4'd0;
            r_target <= w_trig_row;
          end
        end
        FETCH: begin
          r_cap_valid <= 1'b1;
          r_cap_col   <= r_col;
          if (r_col == LAST_COL) begin
            r_state <= DRAIN;
          end else begin
            r_col <= r_col + 4'd1;
          end
        end
        DRAIN: begin
          r_state <= SWAP;
        end
        SWAP: begin
          r_row       <= r_shadow;
          r_row_num   <= r_target;
          r_row_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/board_row_scheduler.md
BOARD_ROW_SCHEDULER -- requirements
Module: board_row_scheduler

Interface
REQ-001 The block SHALL have parameter SQUARE_SIZE, default 21, giving pixel height of one board block row.
REQ-002 The block SHALL have parameter BOARD_ROWS, default 20, giving board rows; BOARD_COLS, default 10, giving cells per row.
REQ-003 The block SHALL have parameter FRAME_LAST, default 524, giving the last DrawY line of a frame.
REQ-004 Clk  in  1  system clock; the block SHALL use one clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 hs  in  1  horizontal sync, active-high end-of-line; DrawY  in  10  current VGA line.
REQ-007 game_req  in  1  game-logic board access request; game_we  in  1  write when 1, read when 0.
REQ-008 game_row  in  5  target row; game_col  in  4  target column; game_wdata  in  16  write cell ({R,G,B} 4b each in [11:0]).
REQ-009 game_gnt  out  1  access granted this cycle; game_rvalid  out  1  game_rdata valid; game_rdata  out  16  read data.
REQ-010 mem_addr  out  8  board RAM address; mem_we  out  1; mem_wdata  out  16; mem_rdata  in  16  (1-cycle read latency).
REQ-011 Row  out  16 x BOARD_COLS  displayed row cells; rowNum  out  8  row held in Row; row_valid  out  1  one-cycle pulse on Row update; fetch_overrun  out  1  sticky error.

Function
REQ-012 hs rising edge (hs=1, previous-cycle hs=0) SHALL form a trigger when (DrawY+1) mod SQUARE_SIZE = 0 and (DrawY+1) < BOARD_ROWS*SQUARE_SIZE, target row (DrawY+1)/SQUARE_SIZE; or when DrawY = FRAME_LAST, target row 0.
REQ-013 The FSM SHALL have states IDLE, FETCH, DRAIN, SWAP; IDLE->FETCH on trigger (cycle T).
REQ-014 In FETCH, cycles T+1..T+10, mem_addr SHALL equal target*BOARD_COLS+c with c = 0..9, mem_we=0; after c=9 -> DRAIN (T+11) -> SWAP (T+12) -> IDLE.
REQ-015 mem_rdata SHALL be captured into a shadow buffer cell c one cycle after address c is issued (T+2..T+11).
REQ-016 At the end of SWAP, Row SHALL load the shadow buffer and rowNum the target row, in the same edge; row_valid SHALL be 1 for exactly cycle T+13.
REQ-017 Row SHALL be stable except at the SWAP edge; a partially fetched row SHALL never be visible on Row.
REQ-018 game_gnt SHALL equal game_req AND state=IDLE AND no trigger this cycle; display fetch wins simultaneous events.
REQ-019 When game_gnt and game_we, mem_addr = game_row*BOARD_COLS+game_col, mem_we=1, mem_wdata=game_wdata in that cycle.
REQ-020 When game_gnt and not game_we, game_rvalid SHALL be 1 in the next cycle with game_rdata = mem_rdata.
REQ-021 game_row >= BOARD_ROWS or game_col >= BOARD_COLS SHALL still be granted; write suppressed (mem_we=0), read returns game_rdata=0 with game_rvalid=1.
REQ-022 A trigger while state != IDLE SHALL be dropped and set fetch_overrun=1 until reset.
REQ-023 Outside game writes, mem_we SHALL be 0 and mem_wdata 0; in IDLE without grant, mem_addr SHALL be 0.

Reset
REQ-024 reset SHALL, on the next edge, regardless of state: state=IDLE, column counter 0, Row and shadow all 0, rowNum=0, row_valid=0, game_rvalid=0, fetch_overrun=0, hs history 0.
REQ-025 Reset mid-FETCH SHALL abort the fetch with no Row update; game_gnt SHALL be 0 while reset is 1.

Structure
REQ-026 Package tetris_pkg SHALL hold BOARD_ROWS, BOARD_COLS, SQUARE_SIZE, FRAME_LAST defaults, the 16-bit cell typedef, and the FSM state enum.
REQ-027 Trigger detection (hs edge, modulo test, target row) SHALL be sub-module row_trigger; FSM, arbitration and buffers stay in the top.

Verification
REQ-028 RAM row 3 preloaded with cells 0x0100+c; hs rise at DrawY=62 -> addresses 30..39 at T+1..T+10, row_valid at T+13, Row[c]=0x0100+c, rowNum=3.
REQ-029 hs rise at DrawY=524 -> fetch of row 0, addresses 0..9; hs rise at DrawY=419 (row 20) and DrawY=100 -> no fetch.
REQ-030 game_req write (row 5, col 7, 0x0F00) in same cycle as trigger -> game_gnt=0 until SWAP completes, then granted; mem_addr=57, mem_we=1.
REQ-031 Game read row 25 col 2 in IDLE -> game_gnt=1, mem_we=0, next cycle game_rvalid=1, game_rdata=0.
REQ-032 Second trigger forced during FETCH -> fetch_overrun=1, first fetch completes unchanged; reset at T+5 of a new fetch -> IDLE, Row=0, rowNum=0, fetch_overrun=0, no row_valid.
